// File: rtl/ray_generator_pkg.sv
// Shared types and helpers for the primary-ray generator.
// Fixed point is signed Q16.16. vec3 is a packed {x, y, z} triple.
// Optional build macro: RAY_GEN_INTERLACE_EN (see ray_generator.sv).
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 640
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 480
`endif
`ifndef H_BITS
`define H_BITS 10
`endif
`ifndef V_BITS
`define V_BITS 9
`endif

package ray_generator_pkg;

   localparam int FP_BITS = 32;
   localparam int FP_FRAC = 16;

   typedef logic signed [FP_BITS-1:0] fp;

   typedef struct packed {
      fp x;
      fp y;
      fp z;
   } vec3;

   localparam fp FP_ONE  = 32'sh0001_0000;
   localparam fp FP_ZERO = 32'sh0000_0000;

   // Widths of the fields carried on the ray stream.
   localparam int VEC3_BITS             = 3 * FP_BITS;
   localparam int DEFAULT_DISPLAY_WIDTH  = `DISPLAY_WIDTH;
   localparam int DEFAULT_DISPLAY_HEIGHT = `DISPLAY_HEIGHT;
   localparam int DEFAULT_H_BITS         = `H_BITS;
   localparam int DEFAULT_V_BITS         = `V_BITS;
   localparam int DEFAULT_SCALE_SHIFT    = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } gen_state_t;

   function automatic fp fp_add(input fp a, input fp b);
      return a + b;
   endfunction

   function automatic fp fp_sub(input fp a, input fp b);
      return a - b;
   endfunction

   // Full-width signed product, then drop the extra fraction bits.
   function automatic fp fp_mul(input fp a, input fp b);
      logic [2*FP_BITS-1:0] prod;
      prod = {{FP_BITS{a[FP_BITS-1]}}, a} * {{FP_BITS{b[FP_BITS-1]}}, b};
      return fp'(prod[FP_FRAC +: FP_BITS]);
   endfunction

   // Whole-number integer to fixed point; wraps on overflow like the rest of the math.
   function automatic fp int_to_fp(input int n);
      return fp'(n) * FP_ONE;
   endfunction

endpackage

// File: rtl/ray_generator_pixel_scanner.sv
// Raster pixel counter for the ray generator: h walks the row, v steps
// down the frame, last flags the final emitted pixel.
// With RAY_GEN_INTERLACE_EN defined only rows whose v[0] equals field are visited.
module ray_generator_pixel_scanner
   import ray_generator_pkg::*;
#(
   parameter int DISPLAY_WIDTH  = DEFAULT_DISPLAY_WIDTH,
   parameter int DISPLAY_HEIGHT = DEFAULT_DISPLAY_HEIGHT,
   parameter int H_BITS         = DEFAULT_H_BITS,
   parameter int V_BITS         = DEFAULT_V_BITS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              advance,
`ifdef RAY_GEN_INTERLACE_EN
   input  logic              field,
`endif
   output logic [H_BITS-1:0] h,
   output logic [V_BITS-1:0] v,
   output logic              last
);

   localparam logic [H_BITS-1:0] H_MAX = H_BITS'(DISPLAY_WIDTH - 1);

   logic [V_BITS-1:0] v_first;
   logic [V_BITS-1:0] v_last;
   logic [V_BITS-1:0] v_step;

`ifdef RAY_GEN_INTERLACE_EN
   assign v_first = V_BITS'(field);
   assign v_last  = V_BITS'(DISPLAY_HEIGHT - 2) + v_first;
   assign v_step  = V_BITS'(2);
`else
   assign v_first = '0;
   assign v_last  = V_BITS'(DISPLAY_HEIGHT - 1);
   assign v_step  = V_BITS'(1);
`endif

   assign last = (h == H_MAX) && (v == v_last);

   // Counter restarts on clear and otherwise steps in raster order when advanced.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h <= '0;
         v <= '0;
      end else if (clear) begin
         h <= '0;
         v <= v_first;
      end else if (advance) begin
         if (h == H_MAX) begin
            h <= '0;
            v <= v + v_step;
         end else begin
            h <= h + H_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/ray_generator.sv
// Primary-ray generator: latches the camera once per frame and streams one
// ray per pixel through a two-stage pipeline (screen offsets, then direction)
// over a valid/ready interface.
// Optional build macro: RAY_GEN_INTERLACE_EN emits alternate rows per frame.
module ray_generator
   import ray_generator_pkg::*;
#(
   parameter int DISPLAY_WIDTH  = DEFAULT_DISPLAY_WIDTH,
   parameter int DISPLAY_HEIGHT = DEFAULT_DISPLAY_HEIGHT,
   parameter int H_BITS         = DEFAULT_H_BITS,
   parameter int V_BITS         = DEFAULT_V_BITS,
   parameter int SCALE_SHIFT    = DEFAULT_SCALE_SHIFT
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              start_in,
   input  vec3               pos_in,
   input  vec3               dir_in,
   output logic              busy_out,
   output logic              frame_done_out,
   output logic              ray_valid_out,
   input  logic              ray_ready_in,
   output vec3               ray_origin_out,
   output vec3               ray_dir_out,
   output logic [H_BITS-1:0] hcount_out,
   output logic [V_BITS-1:0] vcount_out,
   output logic              ray_last_out
);

   gen_state_t state;
   gen_state_t state_next;

   vec3 pos_q;
   vec3 dir_q;

   logic enable;
   logic latch;
   logic feed;
   logic finish;

   logic [H_BITS-1:0] scan_h;
   logic [V_BITS-1:0] scan_v;
   logic              scan_last;

   logic              s1_valid;
   logic              s1_last;
   logic [H_BITS-1:0] s1_h;
   logic [V_BITS-1:0] s1_v;
   fp                 s1_u;
   fp                 s1_vv;

   fp u_next;
   fp vv_next;

`ifdef RAY_GEN_INTERLACE_EN
   logic field;
`endif

   assign enable         = !ray_valid_out || ray_ready_in;
   assign ray_origin_out = pos_q;

   assign u_next  = int_to_fp(int'(scan_h) - DISPLAY_WIDTH / 2) >>> SCALE_SHIFT;
   assign vv_next = int_to_fp(DISPLAY_HEIGHT / 2 - int'(scan_v)) >>> SCALE_SHIFT;

   ray_generator_pixel_scanner #(
      .DISPLAY_WIDTH (DISPLAY_WIDTH),
      .DISPLAY_HEIGHT(DISPLAY_HEIGHT),
      .H_BITS        (H_BITS),
      .V_BITS        (V_BITS)
   ) u_scanner (
      .clk    (clk_in),
      .rst_n  (rst_in),
      .clear  (latch),
      .advance(feed),
`ifdef RAY_GEN_INTERLACE_EN
      .field  (field),
`endif
      .h      (scan_h),
      .v      (scan_v),
      .last   (scan_last)
   );

   // State register.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state plus the per-cycle control strobes.
   always_comb begin
      state_next = state;
      latch      = 1'b0;
      feed       = 1'b0;
      finish     = 1'b0;
      busy_out   = 1'b0;
      case (state)
         IDLE: begin
            if (start_in) begin
               latch      = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            busy_out = 1'b1;
            if (enable) begin
               feed = 1'b1;
               if (scan_last) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            busy_out = 1'b1;
            if (ray_valid_out && ray_ready_in && ray_last_out) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Camera snapshot taken once at frame start so mid-frame motion cannot tear.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         pos_q <= '0;
         dir_q <= '0;
      end else if (latch) begin
         pos_q <= pos_in;
         dir_q <= dir_in;
      end
   end

   // Stage 1: pixel coordinates turned into screen-plane offsets.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_h     <= '0;
         s1_v     <= '0;
         s1_u     <= FP_ZERO;
         s1_vv    <= FP_ZERO;
      end else if (enable) begin
         s1_valid <= feed;
         s1_last  <= scan_last;
         s1_h     <= scan_h;
         s1_v     <= scan_v;
         s1_u     <= u_next;
         s1_vv    <= vv_next;
      end
   end

   // Stage 2: direction = forward + u * right + vv * up, held while stalled.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         ray_valid_out <= 1'b0;
         ray_last_out  <= 1'b0;
         hcount_out    <= '0;
         vcount_out    <= '0;
         ray_dir_out   <= '0;
      end else if (enable) begin
         ray_valid_out <= s1_valid;
         ray_last_out  <= s1_valid && s1_last;
         hcount_out    <= s1_h;
         vcount_out    <= s1_v;
         ray_dir_out.x <= fp_add(dir_q.x, fp_mul(dir_q.z, s1_u));
         ray_dir_out.y <= fp_add(dir_q.y, s1_vv);
         ray_dir_out.z <= fp_sub(dir_q.z, fp_mul(dir_q.x, s1_u));
      end
   end

   // End-of-frame pulse, registered so it lands the cycle after the last ray is taken.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         frame_done_out <= 1'b0;
      end else begin
         frame_done_out <= finish;
      end
   end

`ifdef RAY_GEN_INTERLACE_EN
   // Field flips at every completed frame so consecutive frames cover even then odd rows.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         field <= 1'b0;
      end else if (finish) begin
         field <= !field;
      end
   end
`endif

endmodule

// File: tb/tb_ray_generator.sv
// Testbench for ray_generator: 8x4 display, SCALE_SHIFT=2.
// Directed frame table with hand-computed probe directions, plus reset sequences.
`timescale 1ns/1ps
module tb_ray_generator;
   import ray_generator_pkg::*;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int HB = 3;
   localparam int VB = 2;
   localparam int SS = 2;

`ifdef RAY_GEN_INTERLACE_EN
   localparam bit INTERLACE = 1'b1;
   localparam int ROWS      = H / 2;
`else
   localparam bit INTERLACE = 1'b0;
   localparam int ROWS      = H;
`endif
   localparam int RAYS   = W * ROWS;
   localparam int BUDGET = 400;

   localparam int F1  = 65536;
   localparam int FH  = 32768;
   localparam int FQ  = 16384;
   localparam int F3Q = 49152;

   typedef struct {
      vec3 pos;
      vec3 dir;
      bit  random_ready;
      bit  disturb;
      int  probe_h;
      int  probe_v;
      vec3 exp_dir;
   } frame_vec_t;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          start_in;
   vec3           pos_in;
   vec3           dir_in;
   logic          busy_out;
   logic          frame_done_out;
   logic          ray_valid_out;
   logic          ray_ready_in;
   vec3           ray_origin_out;
   vec3           ray_dir_out;
   logic [HB-1:0] hcount_out;
   logic [VB-1:0] vcount_out;
   logic          ray_last_out;

   int checks = 0;
   int errors = 0;
   bit tb_field = 1'b0;
   frame_vec_t frames[6];

   ray_generator #(
      .DISPLAY_WIDTH (W),
      .DISPLAY_HEIGHT(H),
      .H_BITS        (HB),
      .V_BITS        (VB),
      .SCALE_SHIFT   (SS)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .start_in      (start_in),
      .pos_in        (pos_in),
      .dir_in        (dir_in),
      .busy_out      (busy_out),
      .frame_done_out(frame_done_out),
      .ray_valid_out (ray_valid_out),
      .ray_ready_in  (ray_ready_in),
      .ray_origin_out(ray_origin_out),
      .ray_dir_out   (ray_dir_out),
      .hcount_out    (hcount_out),
      .vcount_out    (vcount_out),
      .ray_last_out  (ray_last_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic vec3 mk(input int x, input int y, input int z);
      vec3 r;
      r.x = fp'(x);
      r.y = fp'(y);
      r.z = fp'(z);
      return r;
   endfunction

   function automatic logic [255:0] snapshot();
      logic [255:0] s;
      s = '0;
      s[198:0] = {ray_valid_out, ray_last_out, hcount_out, vcount_out, ray_origin_out, ray_dir_out};
      return s;
   endfunction

   task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic start, input logic ready);
      rst_in       = rst;
      start_in     = start;
      ray_ready_in = ready;
      @(posedge clk_in);
      #1;
   endtask

   task automatic run_frame(input frame_vec_t t, input int idx);
      int  cycle;
      int  rays;
      int  done_pulses;
      int  first_valid;
      int  exp_h;
      int  exp_v;
      bit  probe_seen;
      bit  disturbed;
      bit  prev_stall;
      bit  start_field;
      logic [255:0] snap;
      logic ready_now;

      start_field = tb_field;
      pos_in   = t.pos;
      dir_in   = t.dir;
      start_in = 1'b1;
      ray_ready_in = 1'b1;
      @(posedge clk_in);
      #1;
      start_in = 1'b0;
      checkOutput($sformatf("f%0d busy after start", idx), 256'(busy_out), 256'(1));
      checkOutput($sformatf("f%0d valid at start edge", idx), 256'(ray_valid_out), 256'(0));

      cycle = 1;
      rays = 0;
      done_pulses = 0;
      first_valid = -1;
      exp_h = 0;
      exp_v = INTERLACE ? int'(start_field) : 0;
      probe_seen = 1'b0;
      disturbed = 1'b0;
      prev_stall = 1'b0;
      snap = '0;

      while (done_pulses == 0 && cycle < BUDGET) begin
         @(posedge clk_in);
         #1;
         cycle++;
         start_in = 1'b0;
         if (prev_stall) begin
            checkOutput($sformatf("f%0d stall hold", idx), snapshot(), snap);
         end
         if (frame_done_out) begin
            done_pulses++;
            checkOutput($sformatf("f%0d rays before done", idx), 256'(rays), 256'(RAYS));
            checkOutput($sformatf("f%0d idle at done", idx), 256'(busy_out), 256'(0));
         end
         if (ray_valid_out && first_valid < 0) begin
            first_valid = cycle;
            checkOutput($sformatf("f%0d first valid latency", idx), 256'(cycle), 256'(3));
         end
         if (t.disturb && !disturbed && rays == 10) begin
            disturbed = 1'b1;
            pos_in   = mk(2 * F1, 2 * F1, 2 * F1);
            dir_in   = mk(FH, 0, FH);
            start_in = 1'b1;
         end
         ready_now = t.random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         ray_ready_in = ready_now;
         if (ray_valid_out && ready_now) begin
            checkOutput($sformatf("f%0d hcount", idx), 256'(hcount_out), 256'(exp_h));
            checkOutput($sformatf("f%0d vcount", idx), 256'(vcount_out), 256'(exp_v));
            checkOutput($sformatf("f%0d origin", idx), 256'(ray_origin_out), 256'(t.pos));
            checkOutput($sformatf("f%0d last flag", idx), 256'(ray_last_out), 256'(rays == RAYS - 1));
            if (exp_h == t.probe_h && exp_v == t.probe_v) begin
               probe_seen = 1'b1;
               checkOutput($sformatf("f%0d probe dir", idx), 256'(ray_dir_out), 256'(t.exp_dir));
            end
            rays++;
            if (exp_h == W - 1) begin
               exp_h = 0;
               exp_v = exp_v + (INTERLACE ? 2 : 1);
            end else begin
               exp_h++;
            end
         end
         prev_stall = ray_valid_out && !ready_now;
         snap = snapshot();
      end

      checkOutput($sformatf("f%0d done pulses", idx), 256'(done_pulses), 256'(1));
      checkOutput($sformatf("f%0d ray count", idx), 256'(rays), 256'(RAYS));
      checkOutput($sformatf("f%0d probe seen", idx), 256'(probe_seen),
                  256'(INTERLACE ? ((t.probe_v % 2) == int'(start_field)) : 1'b1));

      ray_ready_in = 1'b1;
      start_in = 1'b0;
      done_pulses = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_in);
         #1;
         if (frame_done_out || busy_out || ray_valid_out) done_pulses++;
      end
      checkOutput($sformatf("f%0d quiet after done", idx), 256'(done_pulses), 256'(0));
      if (INTERLACE) tb_field = !tb_field;
   endtask

   initial begin
      int pulses;

      rst_in = 1'b0;
      start_in = 1'b0;
      ray_ready_in = 1'b1;
      pos_in = '0;
      dir_in = '0;

      frames[0] = '{pos: mk(0, F1, -(F1 + FH)), dir: mk(0, 0, F1), random_ready: 1'b0, disturb: 1'b0,
                    probe_h: 0, probe_v: 0, exp_dir: mk(-F1, FH, F1)};
      frames[1] = '{pos: mk(FQ, 0, 0), dir: mk(F1, 0, 0), random_ready: 1'b1, disturb: 1'b0,
                    probe_h: 6, probe_v: 1, exp_dir: mk(F1, FQ, -FH)};
      frames[2] = '{pos: mk(0, F1, -(F1 + FH)), dir: mk(0, 0, F1), random_ready: 1'b1, disturb: 1'b1,
                    probe_h: 7, probe_v: 3, exp_dir: mk(F3Q, -FQ, F1)};
      frames[3] = '{pos: mk(2 * F1, 2 * F1, 2 * F1), dir: mk(FH, 0, FH), random_ready: 1'b0, disturb: 1'b0,
                    probe_h: 2, probe_v: 2, exp_dir: mk(FQ, 0, F3Q)};
      frames[4] = '{pos: mk(-F1, -F1, -F1), dir: mk(-F1, 0, 2 * F1), random_ready: 1'b1, disturb: 1'b0,
                    probe_h: 4, probe_v: 0, exp_dir: mk(-F1, FH, 2 * F1)};
      frames[5] = '{pos: mk(0, 0, 0), dir: mk(0, 0, -F1), random_ready: 1'b0, disturb: 1'b0,
                    probe_h: 5, probe_v: 3, exp_dir: mk(-FQ, -FQ, -F1)};

      $display("[TB] reset with start pulses");
      applyStimulus(1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("reset valid", 256'(ray_valid_out), 256'(0));
      checkOutput("reset busy", 256'(busy_out), 256'(0));
      checkOutput("reset done", 256'(frame_done_out), 256'(0));
      checkOutput("reset last", 256'(ray_last_out), 256'(0));
      checkOutput("reset counts", 256'({hcount_out, vcount_out}), 256'(0));
      checkOutput("reset origin", 256'(ray_origin_out), 256'(0));
      checkOutput("reset dir", 256'(ray_dir_out), 256'(0));
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("start during reset ignored", 256'(busy_out), 256'(0));
      applyStimulus(1'b1, 1'b0, 1'b1);

      for (int i = 0; i < 6; i++) begin
         $display("[TB] frame %0d", i);
         run_frame(frames[i], i);
      end

      $display("[TB] reset mid-run");
      pos_in = frames[0].pos;
      dir_in = frames[0].dir;
      applyStimulus(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("valid before abort", 256'(ray_valid_out), 256'(1));
      applyStimulus(1'b0, 1'b0, 1'b1);
      tb_field = 1'b0;
      checkOutput("abort valid", 256'(ray_valid_out), 256'(0));
      checkOutput("abort busy", 256'(busy_out), 256'(0));
      checkOutput("abort done", 256'(frame_done_out), 256'(0));
      checkOutput("abort origin", 256'(ray_origin_out), 256'(0));
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1);
         if (frame_done_out || busy_out) pulses++;
      end
      checkOutput("no done after abort", 256'(pulses), 256'(0));

      $display("[TB] frame after abort");
      run_frame(frames[0], 6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
